joystick_poller: RTL and testbench
==================================

# joystick_poller

Multi-channel SPI poller for PmodJSTK-style 2-axis joysticks. Runs a built-in SPI mode-0 master on a shared SCK/MOSI/MISO bus with one active-low chip select per joystick. Every poll period it reads each joystick in turn with a 5-byte transaction and publishes registered 10-bit X, 10-bit Y and 3 button bits per channel. Sits between the board pins and the paddle/game logic; it also drives the two joystick LEDs per channel.

## Interface
- N_JOY, 2: number of joysticks (1..8).
- CLK_DIV, 50: clk50M cycles per SCK half-period (≥1); default gives 500 kHz SCK.
- BYTE_GAP, 750: idle clk50M cycles for CS setup, between bytes and for CS hold (≥1); default gives 15 µs.
- POLL_PERIOD, 500000: clk50M cycles between poll-round starts (default 10 ms).

Ports:
- clk50M  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new round starts; a round in progress completes.
- leds  in  2*N_JOY  {LD2,LD1} per channel, channel k at [2k+1:2k].
- sck  out  1  SPI clock, idle low.
- mosi  out  1  SPI data out, MSB first.
- miso  in  1  SPI data in, shared.
- cs_n  out  N_JOY  per-channel chip select, active low.
- x  out  10*N_JOY  X position, channel k at [10k+9:10k].
- y  out  10*N_JOY  Y position, same packing.
- btn  out  3*N_JOY  buttons {trigger, btn2, btn1}, channel k at [3k+2:3k].
- valid  out  N_JOY  one-cycle pulse when channel k's x/y/btn update.
- busy  out  1  high while a poll round is in progress.
- overrun  out  1  one-cycle pulse when a poll tick arrives while busy.

## Operation
- Free-running poll counter counts 0..POLL_PERIOD-1; tick on wrap. Tick with enable high and not busy starts a round at channel 0. Tick while busy: dropped, overrun pulses. Tick with enable low: dropped silently.
- Round: channels 0..N_JOY-1 in order, one transaction each; BYTE_GAP cycles with all cs_n high between channels; busy drops after the last channel's DONE.
- FSM per transaction: IDLE -> SETUP (cs_n[k] low, BYTE_GAP cycles) -> SHIFT (8 bits) -> GAP (BYTE_GAP cycles) -> SHIFT ... (5 bytes, no GAP after byte 4) -> HOLD (BYTE_GAP cycles, cs_n still low) -> DONE (cs_n high, outputs update) -> SETUP of next channel after inter-channel gap, or IDLE.
- SPI mode 0: sck low in SETUP/GAP/HOLD; each bit = CLK_DIV cycles low then CLK_DIV cycles high; mosi changes only while sck low, MISO sampled on sck rising edge.
- TX bytes: byte0 = {6'b100000, leds[2k+1], leds[2k]}, leds sampled on entry to SETUP; bytes 1-4 = 8'h00.
- RX bytes: b0 = X[7:0], b1[1:0] = X[9:8], b2 = Y[7:0], b3[1:0] = Y[9:8], b4[2:0] = btn; unused bits ignored.
- Received data held in a shadow register; x/y/btn of channel k update only in DONE, all fields together, never partially.

## Timing
- Reset values: sck 0, mosi 0, cs_n all 1, x/y/btn all 0, valid 0, busy 0, overrun 0, poll counter 0, FSM IDLE.
- Tick at cycle t0: busy and cs_n[0] low at t0+1.
- cs_n low duration per transaction = 6*BYTE_GAP + 80*CLK_DIV cycles.
- valid[k] pulses in the same cycle cs_n[k] returns high; x/y/btn already hold new values in that cycle.
- At most one cs_n bit low at any time.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous); no valid pulse; after release, the first round starts at the next tick.
- enable falling mid-round: round completes normally, all N_JOY valid pulses issued.

## Test plan
- Reset: rst_n low at arbitrary point mid-SHIFT -> cs_n=all 1, sck=0, x/y/btn=0, busy=0 within the same cycle; no valid.
- Single read, N_JOY=2, CLK_DIV=2, BYTE_GAP=4, POLL_PERIOD=2000, MISO model returns 34,02,9A,01,05 -> cs_n[0] low 184 cycles, 40 sck rising edges, x[9:0]=0x234, y[9:0]=0x19A, btn[2:0]=3'b101, valid[0] pulse one cycle.
- MOSI check: leds=4'b0110 -> channel0 byte0 = 8'h82, channel1 byte0 = 8'h81, bytes 1-4 = 00; mosi stable on every rising sck.
- Round ordering: two channels with distinct model data -> channel 0 completes before cs_n[1] falls, gap ≥4 cycles with cs_n=2'b11, each channel's outputs match its own data, other channel unchanged.
- Overrun: POLL_PERIOD=200 with the above transaction length -> overrun pulses on the tick that lands mid-round, no round restart, next round on the following clear tick.
- Enable: enable low before tick -> no cs_n activity, busy stays 0; enable dropped mid-round -> round finishes, both valid pulses seen, no further rounds.

Source files
------------

// File: rtl/joystick_poller.sv
// joystick_poller: SPI mode-0 poller reading N_JOY PmodJSTK joysticks each poll period
// Ports: clk50M/rst_n (async, active-low) clock and reset; enable gates new poll rounds;
//   leds {LD2,LD1} per channel; sck/mosi/miso/cs_n shared SPI bus with per-channel select;
//   x/y (10b) and btn (3b) per channel, valid per-channel update pulse;
//   busy while a round runs; overrun pulses when a poll tick lands during a round.
module joystick_poller #(
  parameter int N_JOY       = 2,
  parameter int CLK_DIV     = 50,
  parameter int BYTE_GAP    = 750,
  parameter int POLL_PERIOD = 500000
) (
  input  logic                  clk50M,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [2*N_JOY-1:0]    leds,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic [N_JOY-1:0]      cs_n,
  output logic [10*N_JOY-1:0]   x,
  output logic [10*N_JOY-1:0]   y,
  output logic [3*N_JOY-1:0]    btn,
  output logic [N_JOY-1:0]      valid,
  output logic                  busy,
  output logic                  overrun
);
  localparam int CNT_MAX = CLK_DIV > BYTE_GAP ? CLK_DIV : BYTE_GAP;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int KW = N_JOY > 1 ? $clog2(N_JOY) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_M1 = CW'(BYTE_GAP - 1);
  localparam logic [PW-1:0] POLL_M1 = PW'(POLL_PERIOD - 1);
  localparam logic [KW-1:0] LAST = KW'(N_JOY - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, DONE, CGAP} state_t;
  state_t state;
  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx, byte_idx;
  logic [KW-1:0] ch, nxt_ch;
  logic [6:0] tx_sr;
  logic [7:0] rx_sr;
  logic [9:0] sx, sy;
  logic [2:0] sb;
  logic tick, start;
  assign tick = poll_cnt == POLL_M1;
  assign nxt_ch = state == IDLE ? '0 : ch + 1'b1;
  // a transaction begins either from a poll tick or after the inter-channel gap
  assign start = state == IDLE ? tick && enable : state == CGAP && cnt == GAP_M1;
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) poll_cnt <= '0;
    else poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
  end
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      ch       <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sx       <= '0;
      sy       <= '0;
      sb       <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      x        <= '0;
      y        <= '0;
      btn      <= '0;
      valid    <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= tick && busy;
      valid   <= '0;
      if (start) begin
        // byte0 = 1000_00,LD2,LD1: MSB goes straight to mosi, the rest waits in tx_sr
        state    <= SETUP;
        busy     <= 1'b1;
        ch       <= nxt_ch;
        cs_n     <= ~(N_JOY'(1) << nxt_ch);
        tx_sr    <= {5'b00000, leds[2*nxt_ch +: 2]};
        mosi     <= 1'b1;
        cnt      <= '0;
        bit_idx  <= '0;
        byte_idx <= '0;
      end else begin
        case (state)
          SETUP, GAP: begin
            cnt   <= cnt == GAP_M1 ? '0 : cnt + 1'b1;
            state <= cnt == GAP_M1 ? SHIFT : state;
          end
          SHIFT: begin
            if (cnt != DIV_M1) cnt <= cnt + 1'b1;
            else begin
              cnt <= '0;
              sck <= ~sck;
              if (!sck) rx_sr <= {rx_sr[6:0], miso};
              else if (bit_idx != 3'd7) begin
                bit_idx <= bit_idx + 1'b1;
                mosi    <= tx_sr[6];
                tx_sr   <= {tx_sr[5:0], 1'b0};
              end else begin
                bit_idx  <= '0;
                byte_idx <= byte_idx + 1'b1;
                mosi     <= 1'b0;
                tx_sr    <= '0;
                state    <= byte_idx == 3'd4 ? HOLD : GAP;
                case (byte_idx)
                  3'd0:    sx[7:0] <= rx_sr;
                  3'd1:    sx[9:8] <= rx_sr[1:0];
                  3'd2:    sy[7:0] <= rx_sr;
                  3'd3:    sy[9:8] <= rx_sr[1:0];
                  default: sb      <= rx_sr[2:0];
                endcase
              end
            end
          end
          HOLD: begin
            if (cnt != GAP_M1) cnt <= cnt + 1'b1;
            else begin
              // publish all fields together in the cycle cs_n returns high
              cnt               <= '0;
              state             <= DONE;
              cs_n              <= '1;
              valid[ch]         <= 1'b1;
              x[10*ch +: 10]    <= sx;
              y[10*ch +: 10]    <= sy;
              btn[3*ch +: 3]    <= sb;
            end
          end
          DONE: begin
            state <= ch == LAST ? IDLE : CGAP;
            busy  <= ch != LAST;
            cnt   <= '0;
          end
          default: cnt <= state == CGAP ? cnt + 1'b1 : '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_joystick_poller.sv
// tb_joystick_poller: directed self-checking bench with a PmodJSTK slave model
module tb_joystick_poller;
  logic clk50M = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [3:0] leds = 4'b0110;
  logic sck, mosi, miso;
  logic [1:0] cs_n, valid;
  logic [19:0] x, y;
  logic [5:0] btn;
  logic busy, overrun;
  joystick_poller #(.N_JOY(2), .CLK_DIV(2), .BYTE_GAP(4), .POLL_PERIOD(200)) dut (
    .clk50M(clk50M), .rst_n(rst_n), .enable(enable), .leds(leds),
    .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n),
    .x(x), .y(y), .btn(btn), .valid(valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk50M = ~clk50M;
  int errors = 0;
  int checks = 0;
  logic [39:0] word [2] = '{40'h34_02_9A_01_05, 40'h78_FF_11_FE_FB};
  int cyc = 0, rc = 40, cur = 0, low_len = 0;
  int last_len [2] = '{0, 0};
  int last_rise [2] = '{0, 0};
  int falls [2] = '{0, 0};
  int vcnt [2] = '{0, 0};
  int vbad = 0, multi = 0, mbad = 0, ovr_cnt = 0, gap_run = 0, last_gap = 0;
  int t_busy = 0, t_ovr = 0, t_v0 = 0, t_cs1 = 0;
  logic [39:0] tx_cap = '0;
  logic [39:0] last_tx [2] = '{40'h0, 40'h0};
  logic [1:0] cs_at_busy = 2'b11, pcs = 2'b11, pval = 2'b00;
  logic psck = 1'b0, pmosi = 1'b0, pbusy = 1'b0;
  logic [9:0] x0_at_v0 = '0, x1_at_v0 = '0;
  logic [39:0] wsel;
  assign wsel = word[cur];
  assign miso = rc < 40 ? wsel[39 - rc] : 1'b0;
  always @(negedge clk50M) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (pcs[k] && !cs_n[k]) begin
        cur = k; rc = 0; low_len = 0; tx_cap = '0; falls[k]++;
        if (k == 1) t_cs1 = cyc;
      end
      if (!pcs[k] && cs_n[k]) begin
        last_len[k] = low_len; last_rise[k] = rc; last_tx[k] = tx_cap;
      end
      if (valid[k]) begin
        vcnt[k]++;
        if (!(cs_n[k] && !pcs[k]) || pval[k]) vbad++;
      end
    end
    if (cs_n != 2'b11) low_len++;
    if (cs_n != 2'b11 && sck && !psck) begin
      rc++;
      tx_cap = {tx_cap[38:0], mosi};
      if (mosi !== pmosi) mbad++;
    end
    if (cs_n == 2'b00) multi++;
    if (valid[0]) begin t_v0 = cyc; x0_at_v0 = x[9:0]; x1_at_v0 = x[19:10]; end
    if (overrun) begin ovr_cnt++; t_ovr = cyc; end
    if (busy && !pbusy) begin t_busy = cyc; cs_at_busy = cs_n; end
    if (!busy) gap_run = 0;
    else if (cs_n == 2'b11) gap_run++;
    else if (gap_run > 0) begin last_gap = gap_run; gap_run = 0; end
    pcs = cs_n; psck = sck; pmosi = mosi; pbusy = busy; pval = valid;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_busy(input logic val, input int bound, input string tag);
    int i = 0;
    while (busy !== val && i < bound) begin
      @(negedge clk50M); #1; i++;
    end
    chk(tag, 64'(busy), 64'(val));
  endtask
  initial begin
    int tb1, tr;
    #12;
    chk("rst_sck", 64'(sck), 0);
    chk("rst_mosi", 64'(mosi), 0);
    chk("rst_cs_n", 64'(cs_n), 2'b11);
    chk("rst_xyb", {x, y, btn}, 0);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_busy_ovr", {busy, overrun}, 0);
    @(negedge clk50M); rst_n = 1'b1;
    repeat (450) @(negedge clk50M);
    #1;
    chk("dis_no_round", 64'(falls[0]), 0);
    chk("dis_busy", 64'(busy), 0);
    chk("dis_no_ovr", 64'(ovr_cnt), 0);
    enable = 1'b1;
    wait_busy(1'b1, 250, "r1_start");
    chk("r1_cs_at_busy", 64'(cs_at_busy), 2'b10);
    tb1 = t_busy;
    wait_busy(1'b0, 500, "r1_end");
    chk("r1_len0", 64'(last_len[0]), 184);
    chk("r1_rises0", 64'(last_rise[0]), 40);
    chk("r1_tx0", last_tx[0], 40'h82_00000000);
    chk("r1_len1", 64'(last_len[1]), 184);
    chk("r1_tx1", last_tx[1], 40'h81_00000000);
    chk("r1_x", x, {10'h378, 10'h234});
    chk("r1_y", y, {10'h211, 10'h19A});
    chk("r1_btn", btn, {3'b011, 3'b101});
    chk("r1_vcnt0", 64'(vcnt[0]), 1);
    chk("r1_vcnt1", 64'(vcnt[1]), 1);
    chk("r1_x0_at_v0", x0_at_v0, 10'h234);
    chk("r1_x1_unchanged", x1_at_v0, 10'h000);
    chk("r1_order", 64'(t_cs1 > t_v0), 1);
    chk("r1_gap_ge4", 64'(last_gap >= 4), 1);
    chk("ovr_count", 64'(ovr_cnt), 1);
    chk("ovr_time", 64'(t_ovr - tb1), 200);
    chk("ovr_no_restart", 64'(falls[0]), 1);
    leds = 4'b1001;
    word[1] = 40'h15_FC_AB_C2_FE;
    wait_busy(1'b1, 100, "r2_start");
    chk("r2_next_tick", 64'(t_busy - tb1), 400);
    repeat (50) @(negedge clk50M);
    enable = 1'b0;
    wait_busy(1'b0, 500, "r2_end");
    chk("r2_vcnt0", 64'(vcnt[0]), 2);
    chk("r2_vcnt1", 64'(vcnt[1]), 2);
    chk("r2_tx0", last_tx[0], 40'h81_00000000);
    chk("r2_tx1", last_tx[1], 40'h82_00000000);
    chk("r2_x", x, {10'h015, 10'h234});
    chk("r2_y", y, {10'h2AB, 10'h19A});
    chk("r2_btn", btn, {3'b110, 3'b101});
    repeat (500) @(negedge clk50M);
    #1;
    chk("r2_no_more_rounds", 64'(falls[0]), 2);
    chk("r2_idle_busy", 64'(busy), 0);
    enable = 1'b1;
    wait_busy(1'b1, 250, "r3_start");
    repeat (30) @(negedge clk50M);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", 64'(cs_n), 2'b11);
    chk("mid_rst_sck_mosi", {sck, mosi}, 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_xyb", {x, y, btn}, 0);
    chk("mid_rst_valid", 64'(valid), 0);
    repeat (3) @(negedge clk50M);
    rst_n = 1'b1;
    #1;
    tr = cyc;
    wait_busy(1'b1, 250, "post_rst_start");
    chk("post_rst_tick", 64'(t_busy - tr), 200);
    chk("post_rst_no_valid", 64'(vcnt[0] + vcnt[1]), 4);
    chk("valid_shape", 64'(vbad), 0);
    chk("one_cs_low", 64'(multi), 0);
    chk("mosi_stable", 64'(mbad), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
